// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-addressed, combinational-read
// data memory. Adds byte/halfword loads and stores on top of the word-only
// memory, doing sub-word stores as a read-modify-write. Alignment and range
// are checked before any memory access.
module load_store_unit #(
  parameter int DEPTH_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;

  // Request fields latched at acceptance
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_err_s;
  logic        accept_s;

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   extract_load = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'h000000, sh[7:0]};
      2'b01:   extract_load = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
      2'b10:   extract_load = word;
      default: extract_load = 32'h0000_0000;
    endcase
  endfunction

  // Replace the addressed lane of the old word with the low bits of the store data.
  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] mask;
    logic [4:0]  shamt;
    shamt = {lane, 3'b000};
    case (size)
      2'b00: begin
        mask        = 32'h0000_00FF << shamt;
        merge_store = (old_word & ~mask) | ((wdata & 32'h0000_00FF) << shamt);
      end
      2'b01: begin
        mask        = 32'h0000_FFFF << shamt;
        merge_store = (old_word & ~mask) | ((wdata & 32'h0000_FFFF) << shamt);
      end
      2'b10:   merge_store = wdata;
      default: merge_store = old_word;
    endcase
  endfunction

  // Error classification of the incoming request (size, alignment, range).
  always_comb begin
    req_err_s = 1'b0;
    if (req_size == 2'b11) begin
      req_err_s = 1'b1;
    end else if ((req_size == 2'b01) && req_addr[0]) begin
      req_err_s = 1'b1;
    end else if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) begin
      req_err_s = 1'b1;
    end else if ({2'b00, req_addr[31:2]} >= DEPTH_L) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = 1'b0;
    end
  end

  assign accept_s = (state_q == IDLE) && req_valid;

  // Next-state and datapath register updates for the access sequence.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rdata_d = 32'h0000_0000;
          if (req_err_s) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d      = 1'b0;
            mem_addr_d = {2'b00, req_addr[31:2]};
            if (req_write && (req_size == 2'b10)) begin
              mem_wdata_d = req_wdata;
              state_d     = WR;
            end else begin
              state_d = RD;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (write_q) begin
          mem_wdata_d = merge_store(mem_rdata, wdata_q, size_q, lane_q);
          state_d     = WR;
        end else begin
          rdata_d = extract_load(mem_rdata, size_q, lane_q, signed_q);
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      WR: begin
        rdata_d = 32'h0000_0000;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          rdata_d = 32'h0000_0000;
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Capture the request fields on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      lane_q   <= 2'b00;
      wdata_q  <= 32'h0000_0000;
    end else if (accept_s) begin
      write_q  <= req_write;
      size_q   <= req_size;
      signed_q <= req_signed;
      lane_q   <= req_addr[1:0];
      wdata_q  <= req_wdata;
    end else begin
      write_q  <= write_q;
      size_q   <= size_q;
      signed_q <= signed_q;
      lane_q   <= lane_q;
      wdata_q  <= wdata_q;
    end
  end

  // Handshake and strobes are decoded from the registered state only.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_read   = (state_q == RD);
  assign mem_write  = (state_q == WR);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, random
// traffic against a byte-level reference memory, and hand-written
// backpressure and mid-operation reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;
  logic        mem_clr;

  int tests  = 0;
  int failed = 0;

  logic [31:0] tb_mem [0:15];
  logic [7:0]  ref_b  [0:63];

  load_store_unit #(.DEPTH_WORDS(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Combinational-read data memory attached to the unit.
  assign mem_rdata = (mem_addr < 32'd16) ? tb_mem[mem_addr[3:0]] : 32'h0000_0000;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= 32'h0000_0000;
    end else if (mem_write && (mem_addr < 32'd16)) begin
      tb_mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte-addressed memory) ----------------
  function automatic logic ref_is_err(input logic [1:0] sz, input logic [31:0] a);
    int nbytes;
    if (sz == 2'b11) return 1'b1;
    nbytes = 1 << sz;
    if ((a % nbytes) != 0) return 1'b1;
    if ((a / 4) >= 16) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < 4; i++) v = v + (32'(ref_b[4*idx+i]) << (8*i));
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_b[int'(a) + i]) << (8*i));
    if (sg && (n < 4) && v[8*n-1]) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) ref_b[int'(a) + i] = 8'((wd >> (8*i)) & 32'hFF);
  endtask

  // ---------------- one complete request/response transaction ----------------
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int hold,
                         output logic [31:0] rd, output logic e, output int lat,
                         output logic rd_seen, output int wr_cnt,
                         output logic [31:0] wr_data, output logic [31:0] wr_addr);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; rd_seen = 1'b0; wr_cnt = 0; wr_data = 32'h0; wr_addr = 32'h0;
    while (!resp_valid && lat < 10) begin
      if (mem_read) rd_seen = 1'b1;
      if (mem_write) begin
        wr_cnt++;
        wr_data = mem_wdata;
        wr_addr = mem_addr;
      end
      @(posedge clk); #1;
      lat++;
    end
    check("resp_timeout", 32'(resp_valid), 32'd1);
    rd = resp_rdata;
    e  = resp_err;
    check("strobes_in_resp", 32'({mem_read, mem_write}), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, rd);
      check("hold_err", 32'(resp_err), 32'(e));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("back_to_idle", 32'({resp_valid, req_ready}), 32'd1);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          midx;
    logic [31:0] mword;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, wa, wdat, exp_rd, hold_rd;
    logic        e, rds, exp_err;
    int          lat, wcnt, exp_lat, bound;
    logic        w, sg;
    logic [1:0]  sz;
    logic [31:0] a, wd;

    // Directed vectors: write, size, signed, addr, wdata, rdata, err, latency, word, word value
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 2, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h09, 32'h0, 32'hFFFFFFBE, 1'b0, 2, -1, 32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h09, 32'h0, 32'h000000BE, 1'b0, 2, -1, 32'h0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 32'hFFFFDEAD, 1'b0, 2, -1, 32'h0});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, 32'h0000DEAD, 1'b0, 2, -1, 32'h0});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 2, -1, 32'h0});
    vecs.push_back('{1'b0, 2'b10, 1'b1, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 2, -1, 32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h08, 32'h0, 32'hFFFFFFEF, 1'b0, 2, -1, 32'h0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h08, 32'h0, 32'hFFFFBEEF, 1'b0, 2, -1, 32'h0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0B, 32'hFFFFFF12, 32'h0, 1'b0, 3, 2, 32'h12ADBEEF});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h08, 32'h1234CAFE, 32'h0, 1'b0, 3, 2, 32'h12ADCAFE});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h12ADCAFE, 1'b0, 2, -1, 32'h0});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1, 2, 32'h12ADCAFE});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h05, 32'h0, 32'h0, 1'b1, 1, -1, 32'h0});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1, -1, 32'h0});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1, -1, 32'h0});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 32'h08, 32'h55555555, 32'h0, 1'b1, 1, 2, 32'h12ADCAFE});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h80000000, 32'h0, 32'h0, 1'b1, 1, -1, 32'h0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h3C, 32'hAABBCCDD, 32'h0, 1'b0, 2, 15, 32'hAABBCCDD});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h3F, 32'h0, 32'h000000AA, 1'b0, 2, -1, 32'h0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h40, 32'h77, 32'h0, 1'b1, 1, -1, 32'h0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h3E, 32'h00001357, 32'h0, 1'b0, 3, 15, 32'h1357CCDD});

    reset = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) ref_b[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; mem_clr = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);

    // Directed table
    foreach (vecs[i]) begin
      run_req(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, 0,
              rd, e, lat, rds, wcnt, wdat, wa);
      if (!vecs[i].exp_err && vecs[i].w) ref_store(vecs[i].sz, vecs[i].a, vecs[i].wd);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_mem_read_seen", i), 32'(rds),
            32'(!vecs[i].exp_err && !(vecs[i].w && vecs[i].sz == 2'b10)));
      check($sformatf("vec%0d_write_count", i), 32'(wcnt), 32'(!vecs[i].exp_err && vecs[i].w));
      if (vecs[i].w && !vecs[i].exp_err) begin
        check($sformatf("vec%0d_wr_addr", i), wa, vecs[i].a >> 2);
        check($sformatf("vec%0d_wr_data", i), wdat, vecs[i].mword);
      end
      if (vecs[i].midx >= 0)
        check($sformatf("vec%0d_mem_word", i), tb_mem[vecs[i].midx], vecs[i].mword);
    end

    // Random traffic against the byte-level reference
    for (int t = 0; t < 150; t++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 71));
      wd = $urandom;
      exp_err = ref_is_err(sz, a);
      if (exp_err)                 exp_lat = 1;
      else if (!w || sz == 2'b10)  exp_lat = 2;
      else                         exp_lat = 3;
      exp_rd = (exp_err || w) ? 32'h0 : ref_load(sz, sg, a);
      run_req(w, sz, sg, a, wd, $urandom_range(0, 2), rd, e, lat, rds, wcnt, wdat, wa);
      if (!exp_err && w) ref_store(sz, a, wd);
      check("rnd_rdata", rd, exp_rd);
      check("rnd_err", 32'(e), 32'(exp_err));
      check("rnd_latency", 32'(lat), 32'(exp_lat));
      check("rnd_write_count", 32'(wcnt), 32'(!exp_err && w));
      if (!exp_err) check("rnd_mem_word", tb_mem[a[5:2]], ref_word(int'(a[5:2])));
    end

    // Backpressure: response held while resp_ready low, stray request ignored
    run_req(1'b1, 2'b10, 1'b0, 32'h0C, 32'h0BADF00D, 0, rd, e, lat, rds, wcnt, wdat, wa);
    ref_store(2'b10, 32'h0C, 32'h0BADF00D);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h0C;
    @(posedge clk); #1;
    req_valid = 1'b0;
    bound = 0;
    while (!resp_valid && bound < 10) begin
      @(posedge clk); #1;
      bound++;
    end
    check("bp_resp_timeout", 32'(resp_valid), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h5A5A5A5A;
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, 32'h0BADF00D);
      check("bp_err", 32'(resp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_no_write", 32'(mem_write), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp_release_ready", 32'(req_ready), 32'd1);
    check("bp_release_valid", 32'(resp_valid), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("bp_stray_not_queued", 32'({mem_read, mem_write, resp_valid}), 32'd0);
    end
    check("bp_mem4_unchanged", tb_mem[4], ref_word(4));

    // Reset during the read phase of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0B; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_in_rd", 32'(mem_read), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_no_write", 32'(mem_write), 32'd0);
    check("rst_mid_no_read", 32'(mem_read), 32'd0);
    check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_mid_quiet", 32'({mem_write, resp_valid}), 32'd0);
    end
    check("rst_mid_mem_unchanged", tb_mem[2], ref_word(2));

    // Unit is usable again after the mid-operation reset
    run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, rd, e, lat, rds, wcnt, wdat, wa);
    check("post_rst_load", rd, ref_load(2'b10, 1'b0, 32'h08));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
